// File: rtl/sys_services_arb.sv
// Round-robin arbiter that serialises client channel commands onto a single
// system-services request/ack/busy handshake, with per-request timeout and abort.
module sys_services_arb #(
  parameter int NUM_CH      = 4,
  parameter int CMD_W       = 16,
  parameter int STAT_W      = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH*CMD_W-1:0]    ch_cmd,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [STAT_W-1:0]          ch_status,
  output logic                       ch_timeout,
  output logic [CMD_W-1:0]           ss_cmd,
  output logic                       ss_req,
  output logic                       ss_abort,
  input  logic                       ss_ack,
  input  logic                       ss_busy,
  input  logic [STAT_W-1:0]          ss_status,
  output logic                       arb_busy,
  output logic [$clog2(NUM_CH)-1:0]  active_ch
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EXEC,
    ABORT,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              win_found;
  logic [CMD_W-1:0]  win_cmd;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              grant;

  // Round-robin search starting at ptr and wrapping upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    win_cmd   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (!win_found && ch_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_cmd = ch_cmd[k*CMD_W +: CMD_W];
      end
    end
  end

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);
  assign grant   = (state == IDLE) && win_found;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (win_found) next_state = ISSUE;
      ISSUE: begin
        if (ss_ack)       next_state = EXEC;
        else if (tmo_hit) next_state = ABORT;
      end
      EXEC: begin
        if (!ss_busy)     next_state = DONE;
        else if (tmo_hit) next_state = ABORT;
      end
      ABORT: if (!ss_busy) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The counter saturates at the limit so a request that slipped into EXEC on
  // the expiry cycle is aborted on its next busy cycle instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      active_ch <= '0;
      ss_cmd    <= '0;
      tmo_cnt   <= '0;
    end else if (grant) begin
      ss_cmd    <= win_cmd;
      active_ch <= win_idx;
      ptr       <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
      tmo_cnt   <= '0;
    end else if ((state == ISSUE || state == EXEC) && !tmo_hit) begin
      tmo_cnt   <= tmo_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_req     <= 1'b0;
      ss_abort   <= 1'b0;
      arb_busy   <= 1'b0;
      ch_ack     <= '0;
      ch_status  <= '0;
      ch_timeout <= 1'b0;
    end else begin
      ss_req     <= (next_state == ISSUE);
      ss_abort   <= (next_state == ABORT);
      arb_busy   <= (next_state != IDLE);
      ch_ack     <= '0;
      ch_status  <= '0;
      ch_timeout <= 1'b0;
      if (next_state == DONE) begin
        ch_ack     <= NUM_CH'(1) << active_ch;
        ch_status  <= (state == ABORT) ? '1 : ss_status;
        ch_timeout <= (state == ABORT);
      end
    end
  end

endmodule

// File: tb/tb_sys_services_arb.sv
// Directed bench for sys_services_arb: single request, latency, contention,
// timeout and its boundary, reset mid-transaction and request withdrawal.
module tb_sys_services_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ch_req;
  logic [63:0] ch_cmd;
  logic [3:0]  ch_ack;
  logic [15:0] ch_status;
  logic        ch_timeout;
  logic [15:0] ss_cmd;
  logic        ss_req;
  logic        ss_abort;
  logic        ss_ack;
  logic        ss_busy;
  logic [15:0] ss_status;
  logic        arb_busy;
  logic [1:0]  active_ch;

  int tests_run   = 0;
  int tests_fail  = 0;
  int overlap_cnt = 0;

  sys_services_arb #(
    .NUM_CH(4), .CMD_W(16), .STAT_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_cmd(ch_cmd),
    .ch_ack(ch_ack), .ch_status(ch_status), .ch_timeout(ch_timeout),
    .ss_cmd(ss_cmd), .ss_req(ss_req), .ss_abort(ss_abort),
    .ss_ack(ss_ack), .ss_busy(ss_busy), .ss_status(ss_status),
    .arb_busy(arb_busy), .active_ch(active_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic ack, input logic busy,
                               input logic [15:0] stat);
    ch_req    = req;
    ss_ack    = ack;
    ss_busy   = busy;
    ss_status = stat;
  endtask

  // Advance n cycles; inputs change and outputs are observed on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (ss_req && ss_abort) overlap_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] outs_all();
    return {22'b0, ss_req, ss_abort, arb_busy, ch_timeout, ch_ack, active_ch, ss_cmd, ch_status};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    int abort_hits;
    int ch1_acks;
    int n_grants;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [1:0] got_order[5];
    logic [3:0] got_ack[5];

    rst_n = 1'b0;
    ch_cmd = '0;
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", outs_all(), 64'd0);
    rst_n = 1'b1;
    step(1);
    checkOutput("idle_after_reset", {63'd0, arb_busy}, 64'd0);

    // Single request on channel 2 with delayed ack and a long busy phase
    ch_cmd = {16'hDDDD, 16'h0001, 16'hBBBB, 16'hAAAA};
    applyStimulus(4'b0100, 1'b0, 1'b0, 16'h0000);
    step(1);
    checkOutput("a_ss_req", {63'd0, ss_req}, 64'd1);
    checkOutput("a_ss_cmd", {48'd0, ss_cmd}, 64'h0001);
    checkOutput("a_active_ch", {62'd0, active_ch}, 64'd2);
    checkOutput("a_arb_busy", {63'd0, arb_busy}, 64'd1);
    ch_cmd[47:32] = 16'hBEEF;
    step(1);
    checkOutput("a_still_issue", {63'd0, ss_req}, 64'd1);
    applyStimulus(4'b0100, 1'b1, 1'b1, 16'h0000);
    step(1);
    checkOutput("a_exec_req_low", {63'd0, ss_req}, 64'd0);
    checkOutput("a_cmd_held", {48'd0, ss_cmd}, 64'h0001);
    ss_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (ch_ack != 4'b0000) acks++;
    end
    checkOutput("a_no_early_ack", 64'(acks), 64'd0);
    ss_busy = 1'b0;
    step(1);
    checkOutput("a_ack", {60'd0, ch_ack}, 64'b0100);
    checkOutput("a_status", {48'd0, ch_status}, 64'h0000);
    checkOutput("a_timeout", {63'd0, ch_timeout}, 64'd0);
    ch_req = 4'b0000;
    step(1);
    checkOutput("a_ack_one_cycle", {60'd0, ch_ack}, 64'd0);
    checkOutput("a_idle", {63'd0, arb_busy}, 64'd0);
    checkOutput("a_active_hold", {62'd0, active_ch}, 64'd2);

    // Minimum latency on channel 1 with immediate system-services response
    applyStimulus(4'b0010, 1'b1, 1'b0, 16'h5A3C);
    step(1);
    checkOutput("b_req_t1", {63'd0, ss_req}, 64'd1);
    checkOutput("b_active_ch", {62'd0, active_ch}, 64'd1);
    step(1);
    checkOutput("b_exec_t2", {61'd0, ss_req, arb_busy, |ch_ack}, 64'b010);
    step(1);
    checkOutput("b_ack_t3", {60'd0, ch_ack}, 64'b0010);
    checkOutput("b_status", {48'd0, ch_status}, 64'h5A3C);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Contention after reset: all channels held, rotation starts at 0
    do_reset();
    ch_cmd = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    applyStimulus(4'b1111, 1'b1, 1'b0, 16'h0000);
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 5; c++) begin
      step(1);
      if (ch_ack != 4'b0000) begin
        got_order[n_grants] = active_ch;
        got_ack[n_grants]   = ch_ack;
        n_grants++;
        if (n_grants == 5) ch_req = 4'b0000;
      end
    end
    checkOutput("c_grant_count", 64'(n_grants), 64'd5);
    for (int i = 0; i < n_grants; i++) begin
      checkOutput($sformatf("c_order%0d", i), {62'd0, got_order[i]}, 64'(exp_order[i]));
      checkOutput($sformatf("c_ack%0d", i), {60'd0, got_ack[i]}, 64'd1 << exp_order[i]);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Timeout while busy in EXEC
    applyStimulus(4'b0001, 1'b1, 1'b1, 16'h1234);
    step(1);
    abort_hits = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (ss_abort) abort_hits++;
    end
    checkOutput("d_no_early_abort", 64'(abort_hits), 64'd0);
    step(1);
    checkOutput("d_abort_at_16", {62'd0, ss_abort, ss_req}, 64'b10);
    step(2);
    checkOutput("d_abort_hold", {62'd0, ss_abort, arb_busy}, 64'b11);
    ss_busy = 1'b0;
    step(1);
    checkOutput("d_ack", {60'd0, ch_ack}, 64'b0001);
    checkOutput("d_status", {48'd0, ch_status}, 64'hFFFF);
    checkOutput("d_timeout", {63'd0, ch_timeout}, 64'd1);
    checkOutput("d_abort_drop", {63'd0, ss_abort}, 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Busy falls on the exact expiry cycle: normal completion wins
    applyStimulus(4'b0001, 1'b1, 1'b1, 16'h0000);
    step(1);
    abort_hits = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (ss_abort) abort_hits++;
    end
    applyStimulus(4'b0001, 1'b1, 1'b0, 16'h1234);
    step(1);
    if (ss_abort) abort_hits++;
    checkOutput("e_ack", {60'd0, ch_ack}, 64'b0001);
    checkOutput("e_timeout", {63'd0, ch_timeout}, 64'd0);
    checkOutput("e_status", {48'd0, ch_status}, 64'h1234);
    checkOutput("e_never_abort", 64'(abort_hits), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Ack arrives on the exact expiry cycle in ISSUE
    applyStimulus(4'b0001, 1'b0, 1'b0, 16'h0777);
    step(1);
    abort_hits = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (ss_abort) abort_hits++;
    end
    ss_ack = 1'b1;
    step(1);
    checkOutput("f_exec", {61'd0, ss_req, ss_abort, arb_busy}, 64'b001);
    ss_ack = 1'b0;
    step(1);
    if (ss_abort) abort_hits++;
    checkOutput("f_ack", {60'd0, ch_ack}, 64'b0001);
    checkOutput("f_status_timeout", {47'd0, ch_timeout, ch_status}, 64'h0777);
    checkOutput("f_never_abort", 64'(abort_hits), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Asynchronous reset while in EXEC
    ch_cmd = {16'hC0DE, 16'h2222, 16'h1111, 16'h0000};
    applyStimulus(4'b0001, 1'b1, 1'b1, 16'h0000);
    step(2);
    checkOutput("g_in_exec", {62'd0, arb_busy, ss_req}, 64'b10);
    #2 rst_n = 1'b0;
    #1 checkOutput("g_async_reset", outs_all(), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (ch_ack != 4'b0000) acks++;
    end
    checkOutput("g_no_ack_after_reset", 64'(acks), 64'd0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 16'h00A5);
    step(1);
    checkOutput("g_active_ch3", {62'd0, active_ch}, 64'd3);
    checkOutput("g_cmd_ch3", {48'd0, ss_cmd}, 64'hC0DE);
    step(2);
    checkOutput("g_ack_ch3", {60'd0, ch_ack}, 64'b1000);
    checkOutput("g_status_ch3", {48'd0, ch_status}, 64'h00A5);
    applyStimulus(4'b0000, 1'b0, 1'b0, 16'h0000);
    step(1);

    // Channel 1 requests only during ISSUE of channel 0; channel 0 drops after grant
    applyStimulus(4'b0001, 1'b0, 1'b0, 16'h0000);
    ch1_acks = 0;
    step(1);
    checkOutput("h_grant_ch0", {62'd0, active_ch}, 64'd0);
    ch_req = 4'b0011;
    step(1);
    if (ch_ack[1]) ch1_acks++;
    applyStimulus(4'b0001, 1'b1, 1'b1, 16'h0000);
    step(1);
    if (ch_ack[1]) ch1_acks++;
    applyStimulus(4'b0000, 1'b0, 1'b1, 16'h0000);
    step(1);
    if (ch_ack[1]) ch1_acks++;
    ss_busy = 1'b0;
    step(1);
    checkOutput("h_ack_after_drop", {60'd0, ch_ack}, 64'b0001);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (ch_ack[1]) ch1_acks++;
    end
    checkOutput("h_ch1_no_ack", 64'(ch1_acks), 64'd0);
    checkOutput("h_idle", {63'd0, arb_busy}, 64'd0);

    checkOutput("req_abort_exclusive", 64'(overlap_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
